ibex_multdiv_ctrl: RTL and testbench

Request/response controller directly upstream of the slow multiplier/divider (ibex_multdiv_slow).
- Accepts one mult/div request from a valid/ready source and registers the operator, signed mode and operands.
- Drives the enable, select and operand inputs of the multdiv core for the whole operation.
- Captures the result into a one-entry response buffer with a valid/ready handshake.
- Provides flush handling (drain-and-discard), because the multdiv core cannot be aborted mid-operation.

---
 rtl/ibex_pkg.sv | 23 ++
 rtl/ibex_multdiv_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ibex_multdiv_ctrl.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared mult/div types: operator encoding and the request controller's FSM states.
package ibex_pkg;

  // Operator encoding understood by the slow multiplier/divider.
  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  // Controller state, kept as plain constants so older code can compare raw bits.
  typedef logic [1:0] md_ctrl_state_e;
  localparam md_ctrl_state_e MD_CTRL_IDLE  = 2'd0;
  localparam md_ctrl_state_e MD_CTRL_BUSY  = 2'd1;
  localparam md_ctrl_state_e MD_CTRL_DRAIN = 2'd2;

  // True for the operators that run on the multiplier half of the core.
  function automatic logic md_is_mult(input md_op_e op);
    return (op == MD_OP_MULL) || (op == MD_OP_MULH);
  endfunction

endpackage

// File: rtl/ibex_multdiv_ctrl.sv
// Request/response controller wrapped around the slow mult/div core.
// Takes one operation at a time, holds the core's inputs steady for the whole
// operation, and parks the result in a one-entry response buffer. Because the
// core cannot be aborted, a flush during an operation drains it and drops the
// result.
//
// Handshakes: a request transfers on a cycle where req_valid_i & req_ready_o
// are both high at the rising edge; a response transfers when rsp_valid_o &
// rsp_ready_i are both high. The source must hold the request stable while
// req_valid_i is high and not yet accepted; rsp_result_o is stable while
// rsp_valid_o is high.
module ibex_multdiv_ctrl import ibex_pkg::*; #(
  parameter int unsigned CntW = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [1:0]           req_op_i,
  input  logic [1:0]           req_signed_mode_i,
  input  logic [31:0]          req_op_a_i,
  input  logic [31:0]          req_op_b_i,

  input  logic                 flush_i,

  output logic                 md_mult_en_o,
  output logic                 md_div_en_o,
  output logic                 md_mult_sel_o,
  output logic                 md_div_sel_o,
  output logic [1:0]           md_operator_o,
  output logic [1:0]           md_signed_mode_o,
  output logic [31:0]          md_op_a_o,
  output logic [31:0]          md_op_b_o,
  output logic                 md_ready_id_o,
  input  logic                 md_valid_i,
  input  logic [31:0]          md_result_i,

  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_result_o,

  output logic                 busy_o,
  output logic [CntW-1:0]      last_latency_o,
  output md_ctrl_state_e       state_o
);

  md_ctrl_state_e  state_q, state_d;
  md_op_e          op_q;
  logic [1:0]      mode_q;
  logic [31:0]     op_a_q, op_b_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_result_q;
  logic [CntW-1:0] cnt_q, cnt_inc, last_lat_q;

  logic idle, active, accept, complete, ready_id, is_mult;

  assign idle     = (state_q == MD_CTRL_IDLE);
  assign active   = ~idle;
  assign accept   = idle & ~flush_i & req_valid_i;
  assign is_mult  = md_is_mult(op_q);
  assign complete = (state_q == MD_CTRL_BUSY) & md_valid_i & ready_id & ~flush_i;

  // Saturating increment; the value captured on completion counts the
  // completing cycle too, so it equals the number of BUSY cycles.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CntW'(1);

  // Core handshake: while busy only take the result if the buffer has room
  // this cycle; while draining always take it so the core can go idle.
  always_comb begin
    ready_id = 1'b0;
    case (state_q)
      MD_CTRL_BUSY:  ready_id = ~rsp_valid_q | rsp_ready_i;
      MD_CTRL_DRAIN: ready_id = 1'b1;
      default:       ready_id = 1'b0;
    endcase
  end

  // Next-state logic; flushing with the result already on the bus skips DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_CTRL_IDLE: begin
        if (accept) state_d = MD_CTRL_BUSY;
      end
      MD_CTRL_BUSY: begin
        if (complete)     state_d = MD_CTRL_IDLE;
        else if (flush_i) state_d = md_valid_i ? MD_CTRL_IDLE : MD_CTRL_DRAIN;
      end
      MD_CTRL_DRAIN: begin
        if (md_valid_i) state_d = MD_CTRL_IDLE;
      end
      default: state_d = MD_CTRL_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= MD_CTRL_IDLE;
    else         state_q <= state_d;
  end

  // Operand registers, loaded only on accept so the core sees stable inputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op_q   <= MD_OP_MULL;
      mode_q <= 2'b00;
      op_a_q <= 32'h0;
      op_b_q <= 32'h0;
    end else if (accept) begin
      op_q   <= md_op_e'(req_op_i);
      mode_q <= req_signed_mode_i;
      op_a_q <= req_op_a_i;
      op_b_q <= req_op_b_i;
    end
  end

  // Per-operation latency counter; restarts on accept, counts BUSY cycles.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                       cnt_q <= '0;
    else if (accept)                   cnt_q <= '0;
    else if (state_q == MD_CTRL_BUSY)  cnt_q <= cnt_inc;
  end

  // Latency of the last op that delivered a result; flushed ops leave it alone.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)       last_lat_q <= '0;
    else if (complete) last_lat_q <= cnt_inc;
  end

  // Response buffer: a load wins over a consume, a flush drops the entry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 32'h0;
    end else if (complete) begin
      rsp_valid_q  <= 1'b1;
      rsp_result_q <= md_result_i;
    end else if (flush_i || rsp_ready_i) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  assign req_ready_o      = idle & ~flush_i;
  assign md_mult_en_o     = active & is_mult;
  assign md_mult_sel_o    = active & is_mult;
  assign md_div_en_o      = active & ~is_mult;
  assign md_div_sel_o     = active & ~is_mult;
  assign md_operator_o    = op_q;
  assign md_signed_mode_o = mode_q;
  assign md_op_a_o        = op_a_q;
  assign md_op_b_o        = op_b_q;
  assign md_ready_id_o    = ready_id;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_result_o     = rsp_result_q;
  assign busy_o           = active;
  assign last_latency_o   = last_lat_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_ibex_multdiv_ctrl.sv
// Bench for ibex_multdiv_ctrl. A small behavioural stand-in for the slow
// mult/div core sits on the md_* side; a cycle model of the controller's
// rules plus an expected-response queue checks every cycle.
module tb_ibex_multdiv_ctrl;
  import ibex_pkg::*;

  localparam int CntW   = 6;
  localparam int SatMax = (1 << CntW) - 1;
  localparam int PH_IDLE  = 0;
  localparam int PH_BUSY  = 1;
  localparam int PH_DRAIN = 2;

  logic            clk;
  logic            rst_n;
  logic            req_valid, req_ready;
  logic [1:0]      req_op, req_mode;
  logic [31:0]     req_a, req_b;
  logic            flush;
  logic            md_mult_en, md_div_en, md_mult_sel, md_div_sel;
  logic [1:0]      md_operator, md_signed_mode;
  logic [31:0]     md_op_a, md_op_b;
  logic            md_ready_id, md_valid;
  logic [31:0]     md_result;
  logic            rsp_valid, rsp_ready;
  logic [31:0]     rsp_result;
  logic            busy;
  logic [CntW-1:0] last_lat;
  md_ctrl_state_e  state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  ibex_multdiv_ctrl #(.CntW(CntW)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_op_i          (req_op),
    .req_signed_mode_i (req_mode),
    .req_op_a_i        (req_a),
    .req_op_b_i        (req_b),
    .flush_i           (flush),
    .md_mult_en_o      (md_mult_en),
    .md_div_en_o       (md_div_en),
    .md_mult_sel_o     (md_mult_sel),
    .md_div_sel_o      (md_div_sel),
    .md_operator_o     (md_operator),
    .md_signed_mode_o  (md_signed_mode),
    .md_op_a_o         (md_op_a),
    .md_op_b_o         (md_op_b),
    .md_ready_id_o     (md_ready_id),
    .md_valid_i        (md_valid),
    .md_result_i       (md_result),
    .rsp_valid_o       (rsp_valid),
    .rsp_ready_i       (rsp_ready),
    .rsp_result_o      (rsp_result),
    .busy_o            (busy),
    .last_latency_o    (last_lat),
    .state_o           (state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- arithmetic reference ----------------
  function automatic logic [31:0] md_calc(input logic [1:0] op, input logic [1:0] mode,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    logic [63:0] p;
    sa = mode[0] ? longint'({{32{a[31]}}, a}) : longint'({32'h0, a});
    sb = mode[1] ? longint'({{32{b[31]}}, b}) : longint'({32'h0, b});
    case (md_op_e'(op))
      MD_OP_MULL: begin r = sa * sb; p = r; return p[31:0]; end
      MD_OP_MULH: begin r = sa * sb; p = r; return p[63:32]; end
      MD_OP_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        r = sa / sb; p = r; return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        r = sa % sb; p = r; return p[31:0];
      end
    endcase
  endfunction

  // ---------------- comparison helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural mult/div core ----------------
  // Starts when selected, produces its result after a programmable delay
  // (one cycle for divide-by-zero), holds it until md_ready_id, and goes idle
  // whenever it is deselected.
  logic        c_busy  = 1'b0;
  logic        c_valid = 1'b0;
  int          c_cnt   = 0;
  logic [31:0] c_res   = 32'h0;
  int          core_lat = 3;   // 0 selects a random delay per operation

  assign md_valid  = c_valid;
  assign md_result = c_res;

  always @(posedge clk) begin
    if (!rst_n || !(md_mult_sel || md_div_sel)) begin
      c_busy  <= 1'b0;
      c_valid <= 1'b0;
    end else if (c_valid) begin
      if (md_ready_id) begin
        c_valid <= 1'b0;
        c_busy  <= 1'b0;
      end
    end else if (c_busy) begin
      if (c_cnt <= 1) c_valid <= 1'b1;
      else            c_cnt   <= c_cnt - 1;
    end else begin
      c_busy <= 1'b1;
      c_res  <= md_calc(md_operator, md_signed_mode, md_op_a, md_op_b);
      if (md_div_sel && md_op_b == 32'h0) c_cnt <= 1;
      else if (core_lat > 0)              c_cnt <= core_lat;
      else                                c_cnt <= int'($urandom_range(1, 10));
    end
  end

  // ---------------- controller model and scoreboard ----------------
  int          m_phase = PH_IDLE;
  logic [1:0]  m_op = 2'b0, m_mode = 2'b0;
  logic [31:0] m_a = 32'h0, m_b = 32'h0;
  int          m_busy_cycles = 0;
  logic        m_rsp_valid = 1'b0;
  logic [31:0] m_rsp_data = 32'h0;
  int          m_last_lat = 0;
  bit          mdl_on = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  always @(negedge clk) begin
    bit          idle, is_mul, cmpl, acc;
    logic        exp_rid;
    logic [31:0] e;
    md_ctrl_state_e exp_state;
    idle   = (m_phase == PH_IDLE);
    is_mul = (m_op == MD_OP_MULL) || (m_op == MD_OP_MULH);
    if (mdl_on) begin
      exp_state = (m_phase == PH_BUSY)  ? MD_CTRL_BUSY :
                  (m_phase == PH_DRAIN) ? MD_CTRL_DRAIN : MD_CTRL_IDLE;
      exp_rid   = (m_phase == PH_BUSY)  ? (!m_rsp_valid || rsp_ready) : (m_phase == PH_DRAIN);
      chk1("req_ready", req_ready, idle && !flush);
      chk1("busy", busy, !idle);
      chk("state", 32'(state_dbg), 32'(exp_state));
      chk1("mult_en", md_mult_en, !idle && is_mul);
      chk1("mult_sel", md_mult_sel, !idle && is_mul);
      chk1("div_en", md_div_en, !idle && !is_mul);
      chk1("div_sel", md_div_sel, !idle && !is_mul);
      chk1("md_ready_id", md_ready_id, exp_rid);
      chk1("rsp_valid", rsp_valid, m_rsp_valid);
      chk("rsp_result", rsp_result, m_rsp_data);
      chk("last_latency", 32'(last_lat), 32'(m_last_lat));
      if (!idle) begin
        chk("md_operator", 32'(md_operator), 32'(m_op));
        chk("md_signed_mode", 32'(md_signed_mode), 32'(m_mode));
        chk("md_op_a", md_op_a, m_a);
        chk("md_op_b", md_op_b, m_b);
      end
      // A response leaves the buffer when consumed without a flush.
      if (rst_n && m_rsp_valid && rsp_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rsp_order: consumed 0x%08h with nothing expected", rsp_result);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_order", rsp_result, e);
        end
        got_q.push_back(rsp_result);
      end
    end

    if (!rst_n) begin
      m_phase = PH_IDLE; m_op = 2'b0; m_mode = 2'b0; m_a = 32'h0; m_b = 32'h0;
      m_busy_cycles = 0; m_rsp_valid = 1'b0; m_rsp_data = 32'h0; m_last_lat = 0;
      exp_q.delete();
      mdl_on = 1'b1;
    end else if (mdl_on) begin
      acc  = idle && req_valid && !flush;
      cmpl = 1'b0;
      if (m_phase == PH_BUSY) begin
        if (m_busy_cycles < SatMax) m_busy_cycles++;
        cmpl = md_valid && (!m_rsp_valid || rsp_ready) && !flush;
      end
      if (cmpl) begin
        e = md_calc(m_op, m_mode, m_a, m_b);
        m_rsp_valid = 1'b1;
        m_rsp_data  = e;
        exp_q.push_back(e);
        m_last_lat  = m_busy_cycles;
      end else if (flush) begin
        m_rsp_valid = 1'b0;
        exp_q.delete();
      end else if (rsp_ready) begin
        m_rsp_valid = 1'b0;
      end
      case (m_phase)
        PH_IDLE: if (acc) begin
          m_phase = PH_BUSY; m_op = req_op; m_mode = req_mode;
          m_a = req_a; m_b = req_b; m_busy_cycles = 0;
        end
        PH_BUSY: begin
          if (cmpl)       m_phase = PH_IDLE;
          else if (flush) m_phase = md_valid ? PH_IDLE : PH_DRAIN;
        end
        default: if (md_valid) m_phase = PH_IDLE;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] mode,
                       input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1; req_op = op; req_mode = mode; req_a = a; req_b = b;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
      tick();
    end
    req_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: request op=%0d not accepted", op);
    end
  endtask

  task automatic wait_rsp(input int n);
    int i;
    i = 0;
    while (got_q.size() < n && i < 500) begin
      tick();
      i++;
    end
    if (got_q.size() < n) begin
      n_cmp++; n_err++;
      $display("FAIL rsp_timeout: got %0d responses expected %0d", got_q.size(), n);
    end
  endtask

  task automatic chk_got(input string name, input int idx, input logic [31:0] exp);
    if (idx < got_q.size()) chk(name, got_q[idx], exp);
    else begin
      n_cmp++; n_err++;
      $display("FAIL %s: response %0d missing expected 0x%08h", name, idx, exp);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int base, gap;
    bit ok;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b0; req_mode = 2'b0;
    req_a = 32'h0; req_b = 32'h0; flush = 1'b0; rsp_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_result", rsp_result, 32'h0);
    chk("rst_last_lat", 32'(last_lat), 32'h0);
    chk("rst_op_a", md_op_a, 32'h0);
    chk("rst_op_b", md_op_b, 32'h0);
    chk("rst_operator", 32'(md_operator), 32'h0);
    chk("rst_mode", 32'(md_signed_mode), 32'h0);
    chk1("rst_mult_en", md_mult_en | md_mult_sel, 1'b0);
    chk1("rst_div_en", md_div_en | md_div_sel, 1'b0);
    chk1("rst_ready_id", md_ready_id, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // MULL 7*6, consumer always ready; core delay 3 gives 5 BUSY cycles
    core_lat = 3;
    issue(MD_OP_MULL, 2'b00, 32'd7, 32'd6);
    wait_rsp(1);
    chk_got("mull_7x6", 0, 32'h0000_002A);
    chk("mull_latency", 32'(last_lat), 32'd5);

    // Signed divide and remainder
    issue(MD_OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_rsp(2);
    chk_got("div_m7_2", 1, 32'hFFFF_FFFD);
    issue(MD_OP_REM, 2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_rsp(3);
    chk_got("rem_m7_2", 2, 32'hFFFF_FFFF);

    // Divide by zero finishes fast: 3 BUSY cycles
    issue(MD_OP_DIV, 2'b00, 32'd5, 32'd0);
    wait_rsp(4);
    chk_got("div_by_zero", 3, 32'hFFFF_FFFF);
    chk("div0_latency", 32'(last_lat), 32'd3);
    issue(MD_OP_REM, 2'b00, 32'd7, 32'd0);
    wait_rsp(5);
    chk_got("rem_by_zero", 4, 32'h0000_0007);
    chk("rem0_latency", 32'(last_lat), 32'd3);

    // Backpressure: first result parked, second op stalls until consumed
    base = got_q.size();
    rsp_ready = 1'b0;
    issue(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000);
    issue(MD_OP_MULL, 2'b00, 32'd5, 32'd5);
    repeat (10) tick();
    @(negedge clk);
    chk1("bp_ready_id", md_ready_id, 1'b0);
    chk1("bp_busy", busy, 1'b1);
    chk1("bp_rsp_valid", rsp_valid, 1'b1);
    chk("bp_rsp_held", rsp_result, 32'h4000_0000);
    repeat (60) tick();
    rsp_ready = 1'b1;
    wait_rsp(base + 2);
    chk_got("bp_first", base, 32'h4000_0000);
    chk_got("bp_second", base + 1, 32'h0000_0019);
    chk("bp_latency_sat", 32'(last_lat), 32'(SatMax));

    // Flush in the 5th BUSY cycle of a divide: drain, no response
    core_lat = 8;
    base = got_q.size();
    issue(MD_OP_DIV, 2'b00, 32'd100, 32'd7);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_state", 32'(state_dbg), 32'(MD_CTRL_DRAIN));
    chk1("flush_rsp_valid", rsp_valid, 1'b0);
    for (int i = 0; i < 50 && busy; i++) tick();
    chk1("flush_idle", busy, 1'b0);
    repeat (2) tick();
    chk("flush_no_rsp", 32'(got_q.size()), 32'(base));
    core_lat = 3;
    issue(MD_OP_MULL, 2'b00, 32'd3, 32'd3);
    wait_rsp(base + 1);
    chk_got("after_flush", base, 32'h0000_0009);

    // Reset in the middle of a divide
    core_lat = 8;
    base = got_q.size();
    issue(MD_OP_DIV, 2'b00, 32'd1000, 32'd3);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_rsp_valid", rsp_valid, 1'b0);
    tick();
    core_lat = 3;
    issue(MD_OP_MULL, 2'b00, 32'd2, 32'd2);
    wait_rsp(base + 1);
    chk_got("after_reset", base, 32'h0000_0004);

    // Random traffic: random ops, delays, backpressure, flushes, rare resets
    core_lat = 0;
    for (int n = 0; n < 400; n++) begin
      req_valid = 1'b1;
      req_op    = 2'($urandom_range(0, 3));
      req_mode  = 2'($urandom_range(0, 3));
      req_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      req_b     = ($urandom_range(0, 5) == 0) ? 32'h0 :
                  ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      ok = 1'b0;
      for (int w = 0; w < 300 && !ok; w++) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
        flush     = ($urandom_range(0, 40) == 0);
        rst_n     = ($urandom_range(0, 600) != 0);
        @(negedge clk);
        ok = req_ready && rst_n;
        tick();
      end
      req_valid = 1'b0;
      if (!ok) begin
        n_cmp++; n_err++;
        $display("FAIL rand_accept_timeout: iteration %0d", n);
      end
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
        flush     = ($urandom_range(0, 40) == 0);
        rst_n     = 1'b1;
        tick();
      end
    end
    flush = 1'b0; rst_n = 1'b1; rsp_ready = 1'b1;
    repeat (40) tick();
    chk1("end_idle", busy, 1'b0);
    chk1("end_rsp_empty", rsp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
